// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: branch condition codes,
// counter init/saturation values and the BHT index width.
package branch_resolve_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic int unsigned index_bits(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Weakly-not-taken: the largest value whose MSB is still 0.
    function automatic int unsigned ctr_init(input int unsigned bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int unsigned ctr_max(input int unsigned bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: saturating direction counters with a combinational
// lookup port for fetch and one training port from resolve.
module branch_history_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int IDX_BITS = index_bits(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_msb,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_max(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    logic [CTR_BITS-1:0] ctr [ENTRIES];
    logic [CTR_BITS-1:0] cur;

    assign cur    = ctr[upd_idx];
    // Read sees the registered value, so a same-cycle update is not visible yet.
    assign rd_msb = ctr[rd_idx][CTR_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            if (upd_taken && cur != CTR_MAX) begin
                ctr[upd_idx] <= cur + CTR_ONE;
            end else if (!upd_taken && cur != '0) begin
                ctr[upd_idx] <= cur - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// End-of-execute branch resolution: condition evaluation, target and
// mispredict computation, BHT training, one-entry valid/ready output stage.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int INSTRUCTION_BITSIZE = 32,
    parameter int BHT_ENTRIES         = 64,
    parameter int COUNTER_BITS        = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [INSTRUCTION_BITSIZE-1:0] pred_pc,
    output logic                           pred_taken,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     funct3,
    input  logic                           is_jal,
    input  logic                           is_jalr,
    input  logic [INSTRUCTION_BITSIZE-1:0] pc,
    input  logic [INSTRUCTION_BITSIZE-1:0] a,
    input  logic [INSTRUCTION_BITSIZE-1:0] b,
    input  logic [INSTRUCTION_BITSIZE-1:0] imm,
    input  logic                           predicted_taken,
    input  logic [INSTRUCTION_BITSIZE-1:0] predicted_target,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_taken,
    output logic [INSTRUCTION_BITSIZE-1:0] out_target,
    output logic [INSTRUCTION_BITSIZE-1:0] out_redirect_pc,
    output logic                           out_mispredict,
    output logic                           out_illegal
);

    localparam int W  = INSTRUCTION_BITSIZE;
    localparam int IB = index_bits(BHT_ENTRIES);

    logic         accept;
    logic         is_cond;
    logic         taken;
    logic         illegal;
    logic         mispredict;
    logic [W-1:0] sum_pc;
    logic [W-1:0] sum_reg;
    logic [W-1:0] target;
    logic [W-1:0] redirect_pc;
    logic         unused_pc_bits;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_cond  = !is_jal && !is_jalr;

    // Only the index slice of the PCs feeds the table.
    assign unused_pc_bits = ^{pred_pc[W-1:IB+2], pred_pc[1:0]};

    always_comb begin
        sum_pc  = pc + imm;
        sum_reg = a + imm;
        taken   = 1'b0;
        illegal = 1'b0;
        target  = sum_pc;
        if (is_jalr) begin
            taken  = 1'b1;
            target = {sum_reg[W-1:1], 1'b0};
        end else if (is_jal) begin
            taken = 1'b1;
        end else begin
            case (funct3)
                F3_BEQ:  taken = (a == b);
                F3_BNE:  taken = (a != b);
                F3_BLT:  taken = ($signed(a) < $signed(b));
                F3_BGE:  taken = ($signed(a) >= $signed(b));
                F3_BLTU: taken = (a < b);
                F3_BGEU: taken = (a >= b);
                default: illegal = 1'b1;
            endcase
        end
        redirect_pc = taken ? target : pc + W'(4);
        mispredict  = (taken != predicted_taken) ||
                      (taken && target != predicted_target);
    end

    branch_history_table #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_BITS (COUNTER_BITS),
        .IDX_BITS (IB)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pred_pc[IB+1:2]),
        .rd_msb    (pred_taken),
        .upd_en    (accept && !flush && is_cond && !illegal),
        .upd_idx   (pc[IB+1:2]),
        .upd_taken (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_taken       <= 1'b0;
            out_target      <= '0;
            out_redirect_pc <= '0;
            out_mispredict  <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid       <= 1'b0;
            out_taken       <= 1'b0;
            out_target      <= '0;
            out_redirect_pc <= '0;
            out_mispredict  <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_taken       <= taken;
            out_target      <= target;
            out_redirect_pc <= redirect_pc;
            out_mispredict  <= mispredict;
            out_illegal     <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Next-generation branch resolution block for the pipelined RV32 core; sits at the end of execute.
- Evaluates all six conditional-branch conditions plus JAL/JALR, computes target and redirect PC, and flags misprediction against the fetch-stage guess.
- Holds a parametrised branch history table (BHT) of saturating counters, read by fetch and trained on every resolved conditional branch.
- Result leaves through a one-entry valid/ready output register.

Parameters:
- INSTRUCTION_BITSIZE, 32, datapath width for operands, PC, immediate and target.
- BHT_ENTRIES, 64, number of counters; power of two, at least 2.
- COUNTER_BITS, 2, width of each saturating counter; at least 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pred_pc  input  INSTRUCTION_BITSIZE  fetch PC for lookup.
- pred_taken  output  1  combinational MSB of counter at index(pred_pc).
- flush  input  1  pipeline flush; discards held and incoming results.
- in_valid  input  1  resolution request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- funct3  input  3  branch condition code.
- is_jal  input  1  unconditional PC-relative jump.
- is_jalr  input  1  unconditional register-indirect jump.
- pc  input  INSTRUCTION_BITSIZE  PC of the instruction.
- a  input  INSTRUCTION_BITSIZE  rs1 value.
- b  input  INSTRUCTION_BITSIZE  rs2 value.
- imm  input  INSTRUCTION_BITSIZE  sign-extended offset.
- predicted_taken  input  1  fetch-stage direction guess.
- predicted_target  input  INSTRUCTION_BITSIZE  fetch-stage target guess.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts the result.
- out_taken  output  1  resolved direction.
- out_target  output  INSTRUCTION_BITSIZE  computed target.
- out_redirect_pc  output  INSTRUCTION_BITSIZE  out_target if taken, else pc+4.
- out_mispredict  output  1  fetch must redirect.
- out_illegal  output  1  funct3 is 010 or 011 on a conditional branch.

Behaviour:
- Reset (rst_n low, async): all outputs 0; every BHT counter is set to weakly-not-taken, i.e. 2^(COUNTER_BITS-1)-1.
- Index: pc[log2(BHT_ENTRIES)+1:2]. The same function is used for pred_pc.
- Condition codes (conditional branch, i.e. neither is_jal nor is_jalr):
  - 000 eq.
  - 001 ne.
  - 100 signed lt.
  - 101 signed ge.
  - 110 unsigned lt.
  - 111 unsigned ge.
  - 010/011: not taken, out_illegal=1, no BHT update.
- is_jal: taken; target = pc+imm.
- is_jalr: taken; target = (a+imm) with bit0 cleared. is_jalr has priority over is_jal. funct3 is ignored for both.
- Conditional branch target = pc+imm. All additions wrap modulo 2^INSTRUCTION_BITSIZE.
- Mispredict = (taken != predicted_taken) || (taken && target != predicted_target). An illegal code is evaluated as not taken.
- Handshake: in_ready = !out_valid || out_ready.
  - On accept, results register in the next cycle (latency 1). out_valid rises and outputs hold stable until out_valid && out_ready.
  - Back-to-back accept and drain in the same cycle is allowed.
- BHT training: on accept of a legal conditional branch, the indexed counter increments if taken, else decrements. It saturates at 2^COUNTER_BITS-1 and 0. JAL/JALR never train.
- Same-cycle update and lookup to the same index: pred_taken reflects the pre-update value.
- Flush:
  - The next cycle sees out_valid=0 and data outputs cleared to 0.
  - A request accepted in the flush cycle is discarded and does not train the BHT.
  - Flush does not alter BHT contents.
  - Flush has priority over accept and drain.
- Reset mid-transaction: the held result is lost and the BHT is re-initialised; no partial state survives.

Decomposition:
- Shared package: funct3 branch codes (BEQ..BGEU), counter init and saturation constants, index-width function.
- One sub-module: branch_history_table. It contains the counter array, async-reset init, the combinational read port and the saturating update port.
- The compare, target and mispredict logic and the output register stay in the top.

Test Plan:
- Reset, then pred_pc=0x100 gives pred_taken=0. A BEQ with a=b=5, pc=0x100, imm=0x20, predicted_taken=0 gives out_taken=1, out_target=0x120, out_mispredict=1 one cycle after accept.
- BLT with a=0xFFFFFFFF, b=1 gives taken. BLTU with the same operands gives not taken. BGE/BGEU with a=b=0 both give taken.
- JALR with a=0x1001, imm=4 gives out_target=0x1004 and taken. With predicted_taken=1 and predicted_target=0x1004, out_mispredict=0.
- Three taken BNE at pc=0x40 move the counter 1→2→3→3 (saturated), and pred_pc=0x40 gives 1. A same-cycle lookup during the first update returns 0.
- Hold out_ready=0 with out_valid=1: in_ready=0, outputs stable over 5 cycles, and an in_valid request is not accepted and does not train.
- funct3=010 gives out_illegal=1, not taken, counter unchanged. Flush asserted with in_valid: out_valid=0 next cycle and the counter is unchanged.
